fetch_queue: RTL
================

Name: fetch_queue

Overview:
Instruction-fetch stage that sits directly upstream of the decode stage and its control decoder. It generates the fetch PC and issues in-order requests to instruction memory. Returned instructions are buffered in a small FIFO that presents instr/pc/pc+4 to decode. It handles decode stalls and taken-branch/jump redirects from execute by flushing the queue and discarding in-flight responses.

Parameters:
XLEN, 32, address/data width
DEPTH, 4, queue entries; power of two, >= 2
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
imem_req  out  1  fetch request valid
imem_addr  out  XLEN  fetch address, word aligned
imem_gnt  in  1  request accepted this cycle
imem_rvalid  in  1  response valid, in request order
imem_rdata  in  XLEN  response instruction word
redirect  in  1  flush and restart fetch (pcsrc from execute)
redirect_pc  in  XLEN  restart target
stall_d  in  1  decode cannot accept this cycle
valid_d  out  1  instr_d/pc_d/pcplus4_d valid
instr_d  out  XLEN  instruction to decode
pc_d  out  XLEN  PC of instr_d
pcplus4_d  out  XLEN  pc_d + 4

Behaviour:
- Reset is asynchronous, active-high. All state clears immediately without a clock edge.
- Reset values: pc_f=RESET_PC, count=0, inflight=0, discard=0, imem_req=0, imem_addr=RESET_PC, valid_d=0, instr_d=32'h0000_0013 (NOP), pc_d=0, pcplus4_d=4.
- State:
  - pc_f: next fetch address.
  - Queue: count 0..DEPTH, each entry holds {instr, pc}.
  - inflight: accepted requests not yet answered, 0..DEPTH.
  - discard: responses to drop, always <= inflight.
- deq = valid_d & !stall_d.
- Issue rule: imem_req = !redirect & (count + inflight - deq < DEPTH). Compute in log2(DEPTH)+2 bits; no underflow or wrap.
- imem_addr = pc_f. While imem_req=1 and imem_gnt=0, imem_addr holds stable.
- Accept: imem_req & imem_gnt. inflight increments and pc_f <= pc_f + 4, with 32-bit wrap (32'hFFFF_FFFC -> 0).
- Response: imem_rvalid decrements inflight.
  - If discard > 0: drop the data and decrement discard.
  - Else: enqueue {imem_rdata, pc of the oldest outstanding request}. Track these PCs in a DEPTH-entry in-order tag FIFO.
- imem_rvalid while inflight=0 is a protocol error. Ignore it; state is unchanged.
- Output: head entry; pcplus4_d = pc_d + 4. While count=0: valid_d=0, instr_d=NOP, pc_d/pcplus4_d hold their last values.
- Minimum latency: response cycle N -> valid_d at cycle N+1 (queue is registered, no bypass).
- Throughput: 1 instruction/cycle when imem_gnt=1, response latency <= DEPTH-1 cycles, and stall_d=0.
- stall_d=1: head is held and outputs are stable. Fetch continues until the issue rule blocks. No entry is lost or duplicated.
- Simultaneous enqueue and dequeue: count unchanged. Also legal when count=DEPTH.
- Redirect (has priority over stall_d and responses), effective in the same cycle:
  - valid_d forced 0, imem_req forced 0, queue cleared.
  - pc_f <= {redirect_pc[XLEN-1:2], 2'b00}.
  - discard <= inflight - imem_rvalid (a response arriving in the redirect cycle is dropped).
  - The tag FIFO is flushed consistently with discard.
- Back-to-back redirects: the later target wins; discard accumulates correctly.
- Fetch resumes the cycle after a redirect, even while discard > 0.

Test Plan:
- Release reset; imem_gnt=1, 1-cycle rvalid, rdata=addr|1 -> imem_addr 0,4,8,...; valid_d first high 2 cycles after first grant; pc_d 0,4,8 consecutive; pcplus4_d=pc_d+4; no bubbles.
- stall_d=1 for 8 cycles, DEPTH=4, 1-cycle memory -> imem_req drops once count+inflight=4; after release pc_d resumes in exact order with no gaps or duplicates.
- imem_gnt low 3 cycles with imem_req high -> imem_addr stable at same value; pc_f advances only on the grant cycle.
- 2 requests in flight (latency 3), redirect=1, redirect_pc=0x100 -> both old responses dropped; next valid_d has pc_d=0x100, pcplus4_d=0x104.
- redirect_pc=0x103 in same cycle as imem_rvalid and stall_d=1 -> valid_d=0 that cycle; response dropped; imem_addr=0x100 next cycle.
- Assert rst between clock edges mid-stream -> valid_d=0, imem_req=0, instr_d=NOP immediately; after release fetch restarts at RESET_PC with no stale response enqueued (memory also reset).

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue
// Instruction-fetch front end. It generates the fetch PC and issues in-order
// requests to instruction memory. It tracks the PC of every outstanding
// request in a tag FIFO. Returned words are buffered in a small queue whose
// head is presented to decode.
//
// A redirect from execute does the following in the same cycle:
//   - clears the queue and the tag FIFO;
//   - restarts fetch at the new target;
//   - counts every still-outstanding response as one to discard.
// Because the outstanding responses come back in order, they are exactly the
// next `discard` responses, so none of them needs a tag.
module fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall_d,
  output logic            valid_d,
  output logic [XLEN-1:0] instr_d,
  output logic [XLEN-1:0] pc_d,
  output logic [XLEN-1:0] pcplus4_d
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = AW + 2;
  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

  // architectural state
  logic [XLEN-1:0] pc_f;
  logic [XLEN-1:0] pc_hold;
  logic [CW-1:0]   count;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   discard;

  // instruction queue and request tag FIFO
  logic [XLEN-1:0] q_instr [DEPTH];
  logic [XLEN-1:0] q_pc    [DEPTH];
  logic [XLEN-1:0] tag_pc  [DEPTH];
  logic [AW-1:0]   q_rd;
  logic [AW-1:0]   q_wr;
  logic [AW-1:0]   t_rd;
  logic [AW-1:0]   t_wr;

  // per-cycle events
  logic            have;
  logic            deq;
  logic            accept;
  logic            rv_ok;
  logic            drop;
  logic            enq;
  logic [SW-1:0]   occupancy;

  // The queue head drives decode. While the queue is empty, the PC outputs
  // hold the last head that was shown.
  assign have      = (count != '0);
  assign valid_d   = have & ~redirect;
  assign deq       = valid_d & ~stall_d;
  assign instr_d   = have ? q_instr[q_rd] : NOP;
  assign pc_d      = have ? q_pc[q_rd] : pc_hold;
  assign pcplus4_d = pc_d + XLEN'(4);

  // Issue only if every accepted word still has a queue slot once this cycle's
  // dequeue is taken into account. The extra width keeps the sum exact.
  assign occupancy = {1'b0, count} + {1'b0, inflight} - {{(SW-1){1'b0}}, deq};
  assign imem_req  = ~rst & ~redirect & (occupancy < SW'(DEPTH));
  assign imem_addr = pc_f;
  assign accept    = imem_req & imem_gnt;

  // A response with nothing outstanding is a protocol error and is ignored.
  assign rv_ok     = imem_rvalid & (inflight != '0);
  assign drop      = rv_ok & (discard != '0);
  assign enq       = rv_ok & ~drop & ~redirect;

  // Fetch PC: a redirect sets it to the word-aligned target; an accepted
  // request advances it by one word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_f <= RESET_PC;
    end else if (redirect) begin
      pc_f <= {redirect_pc[XLEN-1:2], 2'b00};
    end else if (accept) begin
      pc_f <= pc_f + XLEN'(4);
    end
  end

  // Outstanding-request bookkeeping. No request is accepted in a redirect
  // cycle, because imem_req is low in that cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= '0;
      discard  <= '0;
      t_rd     <= '0;
      t_wr     <= '0;
    end else begin
      inflight <= inflight + CW'(accept) - CW'(rv_ok);
      if (redirect) begin
        discard <= inflight - CW'(rv_ok);
        t_rd    <= '0;
        t_wr    <= '0;
      end else begin
        if (drop) begin
          discard <= discard - CW'(1);
        end
        t_wr <= t_wr + AW'(accept);
        t_rd <= t_rd + AW'(enq);
      end
    end
  end

  // Queue occupancy and pointers. A redirect empties the queue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count   <= '0;
      q_rd    <= '0;
      q_wr    <= '0;
      pc_hold <= '0;
    end else begin
      if (have) begin
        pc_hold <= q_pc[q_rd];
      end
      if (redirect) begin
        count <= '0;
        q_rd  <= '0;
        q_wr  <= '0;
      end else begin
        count <= count + CW'(enq) - CW'(deq);
        q_wr  <= q_wr + AW'(enq);
        q_rd  <= q_rd + AW'(deq);
      end
    end
  end

  // Storage arrays. These are only read behind valid pointers, so no reset is
  // needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      tag_pc[t_wr] <= pc_f;
    end
    if (enq) begin
      q_instr[q_wr] <= imem_rdata;
      q_pc[q_wr]    <= tag_pc[t_rd];
    end
  end

endmodule
